// File: rtl/count_arbiter.sv
// Round-robin owner of a shared down counter: grants one requester, latches its count,
// decrements to zero, pulses done. Optional decrement prescaler: COUNT_ARB_PRESCALE_EN.
module count_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH        = 8,
  parameter int PRESCALE_DIV = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] load_val,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       cnt_in,
  output logic                   cnt_latch,
  output logic                   cnt_dec,
  input  logic                   cnt_zero
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] winner;
  logic             anyReq;
  logic             reqG;
  logic             decOk;

  // Scan from ptr+1 upward with wrap; the lowest offset with a set request wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = ptr_q;
    anyReq = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        winner = PTR_W'(idx);
        anyReq = 1'b1;
      end
    end
  end

  assign reqG = req[gidx_q];

`ifdef COUNT_ARB_PRESCALE_EN
  localparam int TICK_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;

  logic [TICK_W-1:0] tick_q, tick_d;

  // Held at zero outside RUN, so every RUN entry starts a fresh prescale period.
  always_comb begin
    tick_d = tick_q;
    if (state_q != RUN)
      tick_d = '0;
    else if (tick_q == TICK_W'(PRESCALE_DIV - 1))
      tick_d = '0;
    else
      tick_d = tick_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) tick_q <= '0;
    else       tick_q <= tick_d;
  end

  assign decOk = (tick_q == TICK_W'(PRESCALE_DIV - 1));
`else
  logic unusedPrescale;
  assign unusedPrescale = ^PRESCALE_DIV;
  assign decOk = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(N_REQ - 1);
      gidx_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
    end
  end

  // Reaching zero takes priority over an abort seen in the same RUN cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          gidx_d        = winner;
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          state_d       = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_zero) begin
          state_d = DONE;
        end else if (!reqG) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = gidx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt       = gnt_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) ? gnt_q : '0;
    cnt_latch = (state_q == LOAD);
    cnt_in    = '0;
    if (state_q == LOAD) cnt_in = load_val[int'(gidx_q)*WIDTH +: WIDTH];
    cnt_dec   = (state_q == RUN) && !cnt_zero && decOk;
  end

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: a job-timeline model checked every cycle,
// a behavioural shared counter, directed literal scenarios, then random traffic.
module tb_count_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int DIV = 4;
`ifdef COUNT_ARB_PRESCALE_EN
  localparam int P = DIV;
`else
  localparam int P = 1;
`endif

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] loadVal;
  logic [N-1:0]   gnt, done;
  logic           busy, cnt_latch, cnt_dec, cnt_zero;
  logic [W-1:0]   cnt_in;

  int checks = 0;
  int errors = 0;

  count_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE_DIV(DIV)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .load_val (loadVal),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .cnt_in   (cnt_in),
    .cnt_latch(cnt_latch),
    .cnt_dec  (cnt_dec),
    .cnt_zero (cnt_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared 8-bit down counter the arbiter drives.
  logic [W-1:0] ctr = '0;
  always @(posedge clock) begin
    if (cnt_latch)    ctr <= cnt_in;
    else if (cnt_dec) ctr <= ctr - 1'b1;
  end
  assign cnt_zero = (ctr == '0);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] lv, input logic rst);
    @(posedge clock);
    #1;
    req     = r;
    loadVal = lv;
    reset   = rst;
  endtask

  // Job timeline model: a grant decided in idle cycle t gives LOAD at t+1, RUN at
  // t+2..t+2+V*P (zero on the last), DONE at t+3+V*P; abort ends a non-zero RUN cycle.
  bit checkEn = 0;
  int cyc = 0;
  bit mActive = 0;
  int mTs, mIdx, mV;
  int mPtr = N - 1;

  always @(negedge clock) begin
    logic [N-1:0] eG, eD;
    logic         eB, eL, eDec, eZero;
    logic [W-1:0] eIn;
    int           off, k, i;
    bit           found, endJob, chkZero;
    if (checkEn) begin
      eG = '0; eD = '0; eB = 0; eL = 0; eDec = 0; eIn = '0; eZero = 0;
      endJob = 0; chkZero = 0; found = 0;
      cyc++;
      if (!mActive) begin
        if (!reset && req != '0) begin
          for (int s = 1; s <= N; s++) begin
            i = (mPtr + s) % N;
            if (!found && req[i]) begin
              found = 1;
              mIdx  = i;
            end
          end
          mActive = 1;
          mTs     = cyc;
        end
      end else begin
        off = cyc - mTs;
        eG[mIdx] = 1'b1;
        eB = 1;
        if (off == 1) begin
          eL  = 1;
          mV  = int'(loadVal[mIdx*W +: W]);
          eIn = W'(mV);
        end else if (off <= 2 + mV*P) begin
          k       = off - 2;
          eDec    = (k < mV*P) && ((k % P) == P - 1);
          eZero   = (off == 2 + mV*P);
          chkZero = 1;
          if (!eZero && !req[mIdx]) endJob = 1;
        end else begin
          eD     = eG;
          endJob = 1;
        end
        if (endJob) begin
          mActive = 0;
          mPtr    = mIdx;
        end
      end
      if (reset) begin
        mActive = 0;
        mPtr    = N - 1;
      end
      checkOutput("gnt", 32'(gnt), 32'(eG));
      checkOutput("done", 32'(done), 32'(eD));
      checkOutput("busy", 32'(busy), 32'(eB));
      checkOutput("cnt_latch", 32'(cnt_latch), 32'(eL));
      checkOutput("cnt_in", 32'(cnt_in), 32'(eIn));
      checkOutput("cnt_dec", 32'(cnt_dec), 32'(eDec));
      if (chkZero) checkOutput("cnt_zero", 32'(cnt_zero), 32'(eZero));
    end
  end

  initial begin
    logic [N*W-1:0] lv;
    logic [N-1:0]   r, prevDone;
    int             decCount, doneCount, nG;
    logic [N-1:0]   lastG;
    logic [N-1:0]   grants[$];
    logic [N-1:0]   rrExp[5];

    reset = 1'b1; req = '0; loadVal = '0;
    repeat (3) @(posedge clock);
    #1;
    checkEn = 1;
    #3;
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Single request, client 2, V=5.
    lv = '0; lv[2*W +: W] = 8'd5;
    applyStimulus(4'b0100, lv, 1'b0);
    decCount = 0;
    for (int c = 1; c <= 5*P + 4; c++) begin
      applyStimulus((c >= 5*P + 4) ? 4'b0000 : 4'b0100, lv, 1'b0);
      #3;
      decCount += int'(cnt_dec);
      if (c == 1) begin
        checkOutput("single_gnt", 32'(gnt), 32'd4);
        checkOutput("single_latch", 32'(cnt_latch), 32'd1);
        checkOutput("single_cnt_in", 32'(cnt_in), 32'd5);
      end
      if (c == 5*P + 3) checkOutput("single_done", 32'(done), 32'd4);
      if (c == 5*P + 4) begin
        checkOutput("single_busy_end", 32'(busy), 32'd0);
        checkOutput("single_dec_count", 32'(decCount), 32'd5);
      end
    end

    // Zero load, client 1.
    lv = '0;
    applyStimulus(4'b0010, lv, 1'b0);
    decCount = 0;
    for (int c = 1; c <= 4; c++) begin
      applyStimulus((c >= 4) ? 4'b0000 : 4'b0010, lv, 1'b0);
      #3;
      decCount += int'(cnt_dec);
      if (c == 3) checkOutput("zero_done", 32'(done), 32'd2);
      if (c == 4) begin
        checkOutput("zero_dec_count", 32'(decCount), 32'd0);
        checkOutput("zero_busy_end", 32'(busy), 32'd0);
      end
    end

    // Abort of a long job on client 3, then arbitration resumes at client 0.
    lv = '0; lv[3*W +: W] = 8'd200; lv[0*W +: W] = 8'd2;
    applyStimulus(4'b1000, lv, 1'b0);
    doneCount = 0;
    for (int c = 1; c <= 18; c++) begin
      if (c < 10)       r = 4'b1000;
      else if (c < 13)  r = 4'b0000;
      else if (c == 13) r = 4'b1001;
      else              r = 4'b0000;
      applyStimulus(r, lv, 1'b0);
      #3;
      if (done != '0) doneCount++;
      if (c == 12) begin
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_no_done", 32'(doneCount), 32'd0);
      end
      if (c == 14) checkOutput("abort_next_gnt", 32'(gnt), 32'd1);
    end

    // Reset in the middle of a V=20 job on client 1.
    lv = '0; lv[1*W +: W] = 8'd20;
    applyStimulus(4'b0010, lv, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c < 6)       r = 4'b0010;
      else if (c < 9)  r = 4'b0111;
      else             r = 4'b0000;
      applyStimulus(r, lv, (c == 6));
      #3;
      if (c == 7) begin
        checkOutput("rst_mid_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_dec", 32'(cnt_dec), 32'd0);
      end
      if (c == 8) checkOutput("rst_mid_next_gnt", 32'(gnt), 32'd1);
    end

    // Round robin: all clients requesting with V=1 after a fresh reset.
    applyStimulus(4'b0000, '0, 1'b1);
    lv = {N{8'd1}};
    lastG = '0;
    for (int c = 0; c < 5*(P + 4) + 2; c++) begin
      applyStimulus(4'b1111, lv, 1'b0);
      #3;
      if (gnt != '0 && gnt != lastG) grants.push_back(gnt);
      lastG = gnt;
    end
    rrExp[0] = 4'b0001; rrExp[1] = 4'b0010; rrExp[2] = 4'b0100;
    rrExp[3] = 4'b1000; rrExp[4] = 4'b0001;
    nG = grants.size();
    checkOutput("rr_grant_count_ge5", 32'(nG >= 5), 32'd1);
    for (int j = 0; j < 5; j++)
      checkOutput($sformatf("rr_grant_%0d", j), (j < nG) ? 32'(grants[j]) : 32'hFFFF_FFFF, 32'(rrExp[j]));
    applyStimulus(4'b0000, lv, 1'b1);

    // Random traffic: requests rise at random, drop after done or occasionally abort.
    r = '0; prevDone = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (prevDone[i])  r[i] = 1'b0;
        else if (!r[i])   r[i] = ($urandom_range(0, 99) < 30);
        else if ($urandom_range(0, 199) == 0) r[i] = 1'b0;
        lv[i*W +: W] = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 60))
                                                     : W'($urandom_range(0, 6));
      end
      applyStimulus(r, lv, ($urandom_range(0, 299) == 0));
      #3;
      prevDone = done;
    end

    applyStimulus('0, '0, 1'b0);
    @(posedge clock);
    #1;
    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
